// File: rtl/timer_counter.sv
// timer_counter: memory-mapped down-counting timer with interrupt request.
//   Word registers: 0 = CTRL {IM, Mode[1:0], Enable}, 1 = PRESET, 2 = COUNT (read-only),
//   3 = unused (reads 0). The count sequence is IDLE -> LOAD -> CNT -> INT.
// Ports:
//   i_clk    rising-edge clock
//   i_reset  synchronous active-high reset
//   i_addr   word offset of the addressed register
//   i_we     write strobe, already qualified by the bridge select
//   i_din    write data
//   o_dout   combinational read data for i_addr
//   o_irq    interrupt request (flag AND IM)
module timer_counter (
  input  logic        i_clk,
  input  logic        i_reset,
  input  logic [1:0]  i_addr,
  input  logic        i_we,
  input  logic [31:0] i_din,
  output logic [31:0] o_dout,
  output logic        o_irq
);

  localparam int unsigned DATA_W = 32;
  localparam int unsigned CTRL_W = 4;

  localparam logic [1:0] ADDR_CTRL   = 2'd0;
  localparam logic [1:0] ADDR_PRESET = 2'd1;
  localparam logic [1:0] ADDR_COUNT  = 2'd2;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_LOAD = 2'd1,
    S_CNT  = 2'd2,
    S_INT  = 2'd3
  } state_t;

  state_t              r_state;
  logic [CTRL_W-1:0]   r_ctrl;
  logic [DATA_W-1:0]   r_preset;
  logic [DATA_W-1:0]   r_count;
  logic                r_flag;

  logic w_wr_ctrl;
  logic w_wr_preset;
  logic w_enable;
  logic w_auto_reload;
  logic w_im;
  logic w_unused;

  assign w_wr_ctrl     = i_we && (i_addr == ADDR_CTRL);
  assign w_wr_preset   = i_we && (i_addr == ADDR_PRESET);
  assign w_enable      = r_ctrl[0];
  // Only mode 01 reloads; 10 and 11 behave as one-shot.
  assign w_auto_reload = (r_ctrl[2:1] == 2'b01);
  assign w_im          = r_ctrl[3];
  // CTRL stores only its low bits; the rest of the write data is dropped.
  assign w_unused      = &{1'b0, i_din[DATA_W-1:CTRL_W]};

  // Bus writes and the count FSM. Later assignments in this block take
  // priority: the FSM setting the flag beats a same-cycle bus clear.
  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      r_state  <= S_IDLE;
      r_ctrl   <= '0;
      r_preset <= '0;
      r_count  <= '0;
      r_flag   <= 1'b0;
    end else begin
      if (w_wr_preset) r_preset <= i_din;
      if (w_wr_ctrl)   r_ctrl   <= i_din[CTRL_W-1:0];
      if (w_wr_ctrl || w_wr_preset) r_flag <= 1'b0;

      case (r_state)
        S_IDLE: begin
          if (w_enable) r_state <= S_LOAD;
        end
        S_LOAD: begin
          r_count <= r_preset;
          r_state <= S_CNT;
        end
        S_CNT: begin
          if (!w_enable) begin
            r_state <= S_IDLE;
          end else if (r_count > DATA_W'(1)) begin
            r_count <= r_count - DATA_W'(1);
          end else begin
            // COUNT of 0 or 1 both terminate, so PRESET=0 acts like 1.
            r_count <= '0;
            r_flag  <= 1'b1;
            r_state <= S_INT;
          end
        end
        S_INT: begin
          if (w_auto_reload) begin
            r_flag  <= 1'b0;
            r_state <= S_LOAD;
          end else begin
            r_state <= S_IDLE;
            // A same-cycle CTRL write keeps the value it wrote.
            if (!w_wr_ctrl) r_ctrl[0] <= 1'b0;
          end
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

  // Read mux.
  always_comb begin
    o_dout = '0;
    case (i_addr)
      ADDR_CTRL:   o_dout = DATA_W'(r_ctrl);
      ADDR_PRESET: o_dout = r_preset;
      ADDR_COUNT:  o_dout = r_count;
      default:     o_dout = '0;
    endcase
  end

  assign o_irq = r_flag & w_im;

endmodule

// File: tb/tb_timer_counter.sv
// tb_timer_counter: directed self-checking bench for timer_counter.
module tb_timer_counter;

  logic        i_clk;
  logic        i_reset;
  logic [1:0]  i_addr;
  logic        i_we;
  logic [31:0] i_din;
  logic [31:0] o_dout;
  logic        o_irq;

  int n_tests;
  int n_fail;

  timer_counter dut (
    .i_clk   (i_clk),
    .i_reset (i_reset),
    .i_addr  (i_addr),
    .i_we    (i_we),
    .i_din   (i_din),
    .o_dout  (o_dout),
    .o_irq   (o_irq)
  );

  initial i_clk = 1'b0;
  always #5 i_clk = ~i_clk;

  // Advance past one rising edge; outputs are then stable for sampling.
  task automatic tick();
    @(posedge i_clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic rd_chk(input string tag, input logic [1:0] a, input logic [31:0] exp);
    i_addr = a;
    #1;
    chk(tag, o_dout, exp);
  endtask

  // Single-cycle bus write; returns just after the write edge.
  task automatic wr(input logic [1:0] a, input logic [31:0] d);
    i_we   = 1'b1;
    i_addr = a;
    i_din  = d;
    tick();
    i_we   = 1'b0;
    i_din  = '0;
  endtask

  initial begin
    logic [31:0] auto_cnt [5];
    auto_cnt[0] = 32'd3; auto_cnt[1] = 32'd2; auto_cnt[2] = 32'd1;
    auto_cnt[3] = 32'd0; auto_cnt[4] = 32'd0;
    n_tests = 0;
    n_fail  = 0;
    i_reset = 1'b1;
    i_we    = 1'b0;
    i_addr  = '0;
    i_din   = '0;

    // Power-on reset
    tick();
    tick();
    chk("por_irq", 32'(o_irq), 32'd0);
    rd_chk("por_ctrl", 2'd0, 32'd0);
    rd_chk("por_preset", 2'd1, 32'd0);
    rd_chk("por_count", 2'd2, 32'd0);
    i_reset = 1'b0;
    tick();

    // One-shot, PRESET=5: COUNT 5..1 at e2..e6, irq from e7 and held
    wr(2'd1, 32'd5);
    wr(2'd0, 32'h9);              // e0
    tick();                       // e1 LOAD
    for (int i = 0; i < 5; i++) begin
      tick();                     // e2..e6
      rd_chk("os_count", 2'd2, 32'(5 - i));
      chk("os_irq_low", 32'(o_irq), 32'd0);
    end
    tick();                       // e7 INT
    chk("os_irq_rise", 32'(o_irq), 32'd1);
    rd_chk("os_count_zero", 2'd2, 32'd0);
    tick();                       // e8 IDLE, Enable cleared
    rd_chk("os_ctrl_en_clr", 2'd0, 32'h8);
    chk("os_irq_hold1", 32'(o_irq), 32'd1);
    tick(); tick(); tick();
    chk("os_irq_hold2", 32'(o_irq), 32'd1);
    wr(2'd0, 32'h0);
    chk("os_irq_clear", 32'(o_irq), 32'd0);

    // PRESET write on the flag-set edge leaves the flag set
    wr(2'd1, 32'd2);
    wr(2'd0, 32'h9);              // e0
    tick(); tick(); tick();       // e1..e3
    wr(2'd1, 32'd7);              // e4: INT entry coincides with write
    chk("simul_irq", 32'(o_irq), 32'd1);
    rd_chk("simul_preset", 2'd1, 32'd7);
    wr(2'd0, 32'h0);
    chk("simul_irq_clr", 32'(o_irq), 32'd0);

    // PRESET=0 behaves like 1: INT at e3
    wr(2'd1, 32'd0);
    wr(2'd0, 32'h9);              // e0
    tick(); tick();               // e2
    chk("p0_irq_e2", 32'(o_irq), 32'd0);
    tick();                       // e3
    chk("p0_irq_e3", 32'(o_irq), 32'd1);
    wr(2'd0, 32'h0);

    // Auto-reload, PRESET=3: irq pulse at e5, e10, e15, ...
    wr(2'd1, 32'd3);
    wr(2'd0, 32'hB);              // e0
    for (int c = 1; c <= 25; c++) begin
      tick();
      chk("ar_irq", 32'(o_irq), (c >= 5 && ((c - 5) % 5) == 0) ? 32'd1 : 32'd0);
      if (c >= 2) rd_chk("ar_count", 2'd2, auto_cnt[(c - 2) % 5]);
    end
    wr(2'd0, 32'h0);
    tick(); tick(); tick();

    // Mask: IM=0 never raises irq; later CTRL write clears the hidden flag
    wr(2'd1, 32'd2);
    wr(2'd0, 32'h1);              // e0
    for (int c = 1; c <= 5; c++) begin
      tick();
      chk("mask_irq", 32'(o_irq), 32'd0);
    end
    rd_chk("mask_ctrl", 2'd0, 32'h0);
    rd_chk("mask_count", 2'd2, 32'd0);
    wr(2'd0, 32'h8);
    chk("mask_unmask_irq", 32'(o_irq), 32'd0);
    tick();
    chk("mask_unmask_irq2", 32'(o_irq), 32'd0);
    wr(2'd0, 32'h0);

    // Stop at 6, bus corner cases, then restart from a new PRESET
    wr(2'd1, 32'd10);
    wr(2'd0, 32'h1);              // e0
    for (int c = 1; c <= 5; c++) tick();
    rd_chk("stop_count7", 2'd2, 32'd7);
    wr(2'd0, 32'h0);              // e6: last decrement
    rd_chk("stop_count6", 2'd2, 32'd6);
    tick();
    rd_chk("stop_hold", 2'd2, 32'd6);
    wr(2'd2, 32'h1234);
    rd_chk("count_wr_ignored", 2'd2, 32'd6);
    wr(2'd3, 32'hFFFF_FFFF);
    rd_chk("addr3_reads0", 2'd3, 32'd0);
    rd_chk("addr3_count", 2'd2, 32'd6);
    rd_chk("addr3_preset", 2'd1, 32'd10);
    rd_chk("addr3_ctrl", 2'd0, 32'd0);
    tick(); tick();
    rd_chk("stop_hold2", 2'd2, 32'd6);
    wr(2'd1, 32'd4);
    wr(2'd0, 32'h9);              // f0
    tick(); tick();               // f2
    rd_chk("restart_count", 2'd2, 32'd4);
    tick(); tick(); tick();       // f5
    chk("restart_irq_f5", 32'(o_irq), 32'd0);
    tick();                       // f6
    chk("restart_irq_f6", 32'(o_irq), 32'd1);
    wr(2'd0, 32'h0);

    // CTRL write on the INT edge overrides the Enable clear
    wr(2'd1, 32'd2);
    wr(2'd0, 32'h9);              // e0
    tick(); tick(); tick(); tick(); // e4 INT
    chk("ovr_irq_e4", 32'(o_irq), 32'd1);
    wr(2'd0, 32'h9);              // e5
    rd_chk("ovr_ctrl", 2'd0, 32'h9);
    chk("ovr_irq_clr", 32'(o_irq), 32'd0);
    tick(); tick();               // e7 CNT
    rd_chk("ovr_reload", 2'd2, 32'd2);
    tick(); tick();               // e9 INT again
    chk("ovr_irq_again", 32'(o_irq), 32'd1);
    wr(2'd0, 32'h0);

    // CTRL upper bits are not stored
    wr(2'd1, 32'd100);
    wr(2'd0, 32'hFFFF_FFFF);
    rd_chk("ctrl_all_ones", 2'd0, 32'hF);
    wr(2'd0, 32'h0);
    rd_chk("ctrl_cleared", 2'd0, 32'h0);

    // Reset mid-count
    wr(2'd1, 32'hDEAD_BEEF);
    wr(2'd0, 32'hB);
    tick(); tick(); tick();
    i_reset = 1'b1;
    for (int r = 0; r < 2; r++) begin
      tick();
      chk("rst_irq", 32'(o_irq), 32'd0);
      rd_chk("rst_ctrl", 2'd0, 32'd0);
      rd_chk("rst_preset", 2'd1, 32'd0);
      rd_chk("rst_count", 2'd2, 32'd0);
      rd_chk("rst_addr3", 2'd3, 32'd0);
    end
    i_reset = 1'b0;
    tick(); tick(); tick();
    rd_chk("post_rst_ctrl", 2'd0, 32'd0);
    rd_chk("post_rst_count", 2'd2, 32'd0);
    chk("post_rst_irq", 32'(o_irq), 32'd0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/timer_counter.md
# timer_counter

Memory-mapped timer/counter: the responder on the processor bus that the `cpu` core drives. It decodes the word address, accepts writes, and returns read data combinationally. It counts down from a programmed preset and raises an interrupt request that the system ties to one `HWInt` line. The block sits behind the address-decode bridge; the bridge gates `we` with the device select.

## Interface
- Parameters: none.
- `clk`  in  1  system clock; every state change happens on the rising edge.
- `reset`  in  1  synchronous, active-high reset.
- `addr`  in  2  word offset `PrAddr[3:2]`:
  - 0 = CTRL
  - 1 = PRESET
  - 2 = COUNT
  - 3 = unused
- `we`  in  1  write strobe for the addressed register, already qualified by the bridge select.
- `din`  in  32  write data (`PrWD`).
- `dout`  out  32  read data for the addressed register (feeds `PrRD` via the bridge).
- `irq`  out  1  interrupt request to `HWInt`.

## Operation
- **Registers**
  - CTRL:
    - [0] Enable
    - [2:1] Mode: 00 = one-shot; 01 = auto-reload; 10/11 behave as 00
    - [3] IM, the interrupt mask (1 = irq allowed)
    - [31:4] are stored as 0 and read as 0
  - PRESET: 32-bit reload value, read/write.
  - COUNT: 32-bit, read-only. Writes to COUNT are ignored.
  - `addr`=3 reads 0; writes to it are ignored.
- **`dout`**: combinational mux of the current register values selected by `addr`. Values written at an edge are visible after that edge.
- **FSM states**: IDLE, LOAD, CNT, INT.
  - IDLE: if Enable=1, go to LOAD.
  - LOAD: COUNT <= PRESET; go to CNT.
  - CNT:
    - if Enable=0, go to IDLE; COUNT holds.
    - else if COUNT > 1, COUNT <= COUNT-1.
    - else (COUNT is 0 or 1), COUNT <= 0, set the interrupt flag, go to INT.
  - INT:
    - Mode 01: go to LOAD.
    - Otherwise: Enable <= 0, go to IDLE.
- **Interrupt flag**
  - Mode 00: the flag stays set until a bus write to CTRL or PRESET.
  - Mode 01: the flag is cleared on the INT->LOAD edge, so it is high for exactly one cycle.
- **`irq`** = flag AND IM.
- **Write priority**: a bus write to CTRL in the same cycle as the INT-state Enable clear wins, and CTRL takes `din`. Writing PRESET during CNT does not restart the count; it takes effect at the next LOAD.
- Clearing Enable mid-count stops the count on the next edge. Re-enabling restarts from LOAD with the current PRESET.

## Timing
- **Reset** (synchronous): CTRL=0, PRESET=0, COUNT=0, state=IDLE, flag=0.
  - `irq`=0 and `dout`=0 for every `addr` from the first edge with `reset`=1.
  - Reset mid-count aborts immediately; no irq is produced.
- **Latency, one-shot with PRESET=N (N≥1)**:
  - CTRL written with Enable=1 at edge e0.
  - LOAD at e1.
  - CNT with COUNT=N at e2.
  - INT and COUNT=0 at e2+N; `irq` rises after edge e2+N.
  - IDLE with Enable=0 at e3+N.
- **PRESET=0**: behaves like N=1, with INT at e3.
- **Auto-reload period**: N+2 cycles from one INT to the next. `irq` is a one-cycle pulse per period.
- **Simultaneous flag clear and set**: a bus write to CTRL/PRESET in the same cycle the FSM sets the flag leaves the flag set.

## Test plan
- **Reset**: assert `reset` for 2 cycles after random writes -> all reads return 0, `irq`=0, and the FSM stays in IDLE with Enable=0.
- **One-shot**: write PRESET=5, then CTRL=0x9 -> COUNT reads 5,4,3,2,1 on successive cycles; `irq` rises 7 cycles after the CTRL write edge and holds; Enable reads 0. Writing CTRL=0 then drops `irq`.
- **Auto-reload**: PRESET=3, CTRL=0xB -> a one-cycle `irq` pulse every 5 cycles, sustained across 4 periods; COUNT pattern 3,2,1,0,(LOAD)...
- **Mask**: PRESET=2, CTRL=0x1 (IM=0) -> COUNT reaches 0 and Enable clears, `irq` never asserts. A subsequent CTRL=0x8 write clears the flag, so `irq` stays 0.
- **Stop and restart**: PRESET=10, CTRL=0x1; at COUNT=6 write CTRL=0 -> COUNT holds 6. Then write PRESET=4 and CTRL=0x9 -> the count restarts from 4 and `irq` fires 6 cycles later.
- **Bus corner cases**:
  - Writes to COUNT and to `addr`=3 change nothing; `addr`=3 reads 0.
  - CTRL write data 0xFFFFFFFF reads back 0xF.
  - A CTRL write on the INT edge overrides the automatic Enable clear.
